// File: rtl/multi_wb_stage_pkg.sv
// Shared definitions for the multi-lane writeback stage: lane field widths,
// exception bit indices, ECODE/ESUBCODE values and the per-bit decode helper.
package multi_wb_stage_pkg;

  localparam int PC_W    = 32;
  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int EXCP_W  = 16;
  localparam int ECODE_W = 6;
  localparam int ESUB_W  = 9;

  // Bit positions inside excp_num; lower index means higher priority.
  localparam int EXCP_INT    = 0;
  localparam int EXCP_ADEF   = 1;
  localparam int EXCP_TLBR_F = 2;
  localparam int EXCP_PIF    = 3;
  localparam int EXCP_PPI_F  = 4;
  localparam int EXCP_SYS    = 5;
  localparam int EXCP_BRK    = 6;
  localparam int EXCP_INE    = 7;
  localparam int EXCP_IPE    = 8;
  localparam int EXCP_ALE    = 9;
  localparam int EXCP_RSVD   = 10;
  localparam int EXCP_ADEM   = 11;
  localparam int EXCP_TLBR_M = 12;
  localparam int EXCP_PIL    = 13;
  localparam int EXCP_PME    = 14;
  localparam int EXCP_PPI_M  = 15;

  localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_PIL  = 6'h01;
  localparam logic [ECODE_W-1:0] ECODE_PIF  = 6'h03;
  localparam logic [ECODE_W-1:0] ECODE_PME  = 6'h04;
  localparam logic [ECODE_W-1:0] ECODE_PPI  = 6'h07;
  localparam logic [ECODE_W-1:0] ECODE_ADE  = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
  localparam logic [ECODE_W-1:0] ECODE_IPE  = 6'h0E;
  localparam logic [ECODE_W-1:0] ECODE_TLBR = 6'h3F;

  localparam logic [ESUB_W-1:0] ESUB_ADEF = 9'h000;
  localparam logic [ESUB_W-1:0] ESUB_ADEM = 9'h001;

  typedef struct packed {
    logic [ECODE_W-1:0] ecode;
    logic [ESUB_W-1:0]  esubcode;
    logic               va_error;
    logic [PC_W-1:0]    bad_va;
  } excp_info_t;

  // Fetch-side faults report the pc, data-side faults report the access address.
  function automatic excp_info_t excp_bit_info(input int b,
                                               input logic [PC_W-1:0] pc,
                                               input logic [PC_W-1:0] error_va);
    excp_info_t info;
    info = '0;
    case (b)
      EXCP_INT:    info.ecode = ECODE_INT;
      EXCP_ADEF:   begin info.ecode = ECODE_ADE;  info.esubcode = ESUB_ADEF; info.va_error = 1'b1; info.bad_va = pc; end
      EXCP_TLBR_F: begin info.ecode = ECODE_TLBR; info.va_error = 1'b1; info.bad_va = pc; end
      EXCP_PIF:    begin info.ecode = ECODE_PIF;  info.va_error = 1'b1; info.bad_va = pc; end
      EXCP_PPI_F:  begin info.ecode = ECODE_PPI;  info.va_error = 1'b1; info.bad_va = pc; end
      EXCP_SYS:    info.ecode = ECODE_SYS;
      EXCP_BRK:    info.ecode = ECODE_BRK;
      EXCP_INE:    info.ecode = ECODE_INE;
      EXCP_IPE:    info.ecode = ECODE_IPE;
      EXCP_ALE:    begin info.ecode = ECODE_ALE;  info.va_error = 1'b1; info.bad_va = error_va; end
      EXCP_ADEM:   begin info.ecode = ECODE_ADE;  info.esubcode = ESUB_ADEM; info.va_error = 1'b1; info.bad_va = error_va; end
      EXCP_TLBR_M: begin info.ecode = ECODE_TLBR; info.va_error = 1'b1; info.bad_va = error_va; end
      EXCP_PIL:    begin info.ecode = ECODE_PIL;  info.va_error = 1'b1; info.bad_va = error_va; end
      EXCP_PME:    begin info.ecode = ECODE_PME;  info.va_error = 1'b1; info.bad_va = error_va; end
      EXCP_PPI_M:  begin info.ecode = ECODE_PPI;  info.va_error = 1'b1; info.bad_va = error_va; end
      default:     info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/multi_wb_stage_excp_decode.sv
// Fixed-priority exception decoder: the lowest set excp_num bit (reserved bit
// skipped) selects ecode/esubcode and the faulting address.
module wb_excp_decode
  import multi_wb_stage_pkg::*;
(
  input  logic [EXCP_W-1:0] excp_num,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   error_va,
  output excp_info_t        info
);

  // Scan from the lowest priority upward so the highest-priority bit lands last.
  always_comb begin
    info = '0;
    for (int b = EXCP_W - 1; b >= 0; b--) begin
      if (excp_num[b] && (b != EXCP_RSVD)) begin
        info = excp_bit_info(b, pc, error_va);
      end
    end
  end

endmodule

// File: rtl/multi_wb_stage.sv
// Multi-lane writeback stage: retires an in-order lane group, resolves the
// oldest exception/ertn/CSR/refetch lane into flushes and CSR updates.
module multi_wb_stage
  import multi_wb_stage_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ms_to_ws_valid,
  input  logic [LANES-1:0]          ms_lane_vld,
  input  logic [PC_W*LANES-1:0]     ms_pc,
  input  logic [DATA_W*LANES-1:0]   ms_result,
  input  logic [REG_W*LANES-1:0]    ms_dest,
  input  logic [LANES-1:0]          ms_gr_we,
  input  logic [LANES-1:0]          ms_ertn,
  input  logic [LANES-1:0]          ms_csr_we,
  input  logic [LANES-1:0]          ms_refetch,
  input  logic [EXCP_W*LANES-1:0]   ms_excp_num,
  input  logic [PC_W*LANES-1:0]     ms_error_va,
  input  logic                      csr_busy,
  output logic                      ws_allowin,
  output logic [LANES-1:0]          rf_we,
  output logic [REG_W*LANES-1:0]    rf_waddr,
  output logic [DATA_W*LANES-1:0]   rf_wdata,
  output logic                      excp_flush,
  output logic                      ertn_flush,
  output logic                      refetch_flush,
  output logic                      csr_wr_en,
  output logic [PC_W-1:0]           csr_era,
  output logic [ECODE_W-1:0]        csr_ecode,
  output logic [ESUB_W-1:0]         csr_esubcode,
  output logic [PC_W-1:0]           bad_va,
  output logic                      va_error,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic [CNT_W-1:0]          excp_cnt
);

  logic                ws_valid;
  logic [LANES-1:0]    r_vld, r_gr_we, r_ertn, r_csr_we, r_refetch;
  logic [PC_W-1:0]     r_pc     [LANES];
  logic [DATA_W-1:0]   r_result [LANES];
  logic [REG_W-1:0]    r_dest   [LANES];
  logic [EXCP_W-1:0]   r_excp   [LANES];
  logic [PC_W-1:0]     r_va     [LANES];

  logic                has_head;
  int                  head_pos;
  logic [PC_W-1:0]     head_pc, head_va;
  logic [EXCP_W-1:0]   head_excp;
  logic                head_ertn, head_csr_we, head_refetch, head_clean;
  logic                ready_go, fire;
  logic [LANES-1:0]    retiring, shadowed;
  logic [CNT_W-1:0]    retire_inc;
  excp_info_t          head_info;

  // The group payload is deliberately not reset; ws_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) begin
      r_vld     <= ms_lane_vld;
      r_gr_we   <= ms_gr_we;
      r_ertn    <= ms_ertn;
      r_csr_we  <= ms_csr_we;
      r_refetch <= ms_refetch;
      for (int i = 0; i < LANES; i++) begin
        r_pc[i]     <= ms_pc[i*PC_W +: PC_W];
        r_result[i] <= ms_result[i*DATA_W +: DATA_W];
        r_dest[i]   <= ms_dest[i*REG_W +: REG_W];
        r_excp[i]   <= ms_excp_num[i*EXCP_W +: EXCP_W];
        r_va[i]     <= ms_error_va[i*PC_W +: PC_W];
      end
    end
  end

  // head_pos stays at LANES when no lane needs special handling.
  always_comb begin
    has_head     = 1'b0;
    head_pos     = LANES;
    head_pc      = '0;
    head_va      = '0;
    head_excp    = '0;
    head_ertn    = 1'b0;
    head_csr_we  = 1'b0;
    head_refetch = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!has_head && r_vld[i] &&
          ((|r_excp[i]) || r_ertn[i] || r_csr_we[i] || r_refetch[i])) begin
        has_head     = 1'b1;
        head_pos     = i;
        head_pc      = r_pc[i];
        head_va      = r_va[i];
        head_excp    = r_excp[i];
        head_ertn    = r_ertn[i];
        head_csr_we  = r_csr_we[i];
        head_refetch = r_refetch[i];
      end
    end
  end

  assign head_clean = (head_excp == '0);
  assign ready_go   = !(csr_busy && has_head && head_clean && head_csr_we);
  assign fire       = ws_valid && ready_go;
  assign ws_allowin = !ws_valid || ready_go;

  always_comb begin
    retiring   = '0;
    retire_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      retiring[i] = r_vld[i] && ((i < head_pos) || ((i == head_pos) && head_clean));
      retire_inc  = retire_inc + CNT_W'(retiring[i]);
    end
  end

  // An older lane's write is dropped when a younger retiring lane overwrites it.
  always_comb begin
    shadowed = '0;
    rf_we    = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (retiring[j] && r_gr_we[j] && (r_dest[j] == r_dest[i])) begin
          shadowed[i] = 1'b1;
        end
      end
      rf_we[i] = fire && retiring[i] && r_gr_we[i] && (r_dest[i] != '0) && !shadowed[i];
      if (ws_valid) begin
        rf_waddr[i*REG_W +: REG_W]   = r_dest[i];
        rf_wdata[i*DATA_W +: DATA_W] = r_result[i];
      end
    end
  end

  wb_excp_decode u_excp_decode (
    .excp_num (head_excp),
    .pc       (head_pc),
    .error_va (head_va),
    .info     (head_info)
  );

  assign excp_flush    = fire && has_head && !head_clean;
  assign ertn_flush    = fire && has_head && head_clean && head_ertn;
  assign refetch_flush = fire && has_head && head_clean && !head_ertn && (head_csr_we || head_refetch);
  assign csr_wr_en     = fire && has_head && head_clean && head_csr_we;
  assign csr_era       = (ws_valid && has_head) ? head_pc : '0;
  assign csr_ecode     = ws_valid ? head_info.ecode    : '0;
  assign csr_esubcode  = ws_valid ? head_info.esubcode : '0;
  assign bad_va        = ws_valid ? head_info.bad_va   : '0;
  assign va_error      = ws_valid && head_info.va_error;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid   <= 1'b0;
      retire_cnt <= '0;
      excp_cnt   <= '0;
    end else begin
      if (excp_flush || ertn_flush || refetch_flush) begin
        ws_valid <= 1'b0;
      end else if (ws_allowin) begin
        ws_valid <= ms_to_ws_valid;
      end
      if (fire) begin
        retire_cnt <= retire_cnt + retire_inc;
      end
      if (excp_flush) begin
        excp_cnt <= excp_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_wb_stage.sv
// Directed bench for multi_wb_stage (2 lanes, 4-bit counters so the retire
// counter wrap is reachable quickly).
module tb_multi_wb_stage;

  localparam int LANES = 2;
  localparam int CNT_W = 4;

  logic                 clk;
  logic                 resetn;
  logic                 ms_to_ws_valid;
  logic [LANES-1:0]     ms_lane_vld;
  logic [32*LANES-1:0]  ms_pc, ms_result, ms_error_va;
  logic [5*LANES-1:0]   ms_dest;
  logic [LANES-1:0]     ms_gr_we, ms_ertn, ms_csr_we, ms_refetch;
  logic [16*LANES-1:0]  ms_excp_num;
  logic                 csr_busy;
  logic                 ws_allowin;
  logic [LANES-1:0]     rf_we;
  logic [5*LANES-1:0]   rf_waddr;
  logic [32*LANES-1:0]  rf_wdata;
  logic                 excp_flush, ertn_flush, refetch_flush, csr_wr_en;
  logic [31:0]          csr_era, bad_va;
  logic [5:0]           csr_ecode;
  logic [8:0]           csr_esubcode;
  logic                 va_error;
  logic [CNT_W-1:0]     retire_cnt, excp_cnt;

  int checks;
  int failures;
  logic [CNT_W-1:0] exp_retire;
  logic [CNT_W-1:0] exp_excp;

  multi_wb_stage #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_lane_vld(ms_lane_vld),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest),
    .ms_gr_we(ms_gr_we), .ms_ertn(ms_ertn), .ms_csr_we(ms_csr_we),
    .ms_refetch(ms_refetch), .ms_excp_num(ms_excp_num), .ms_error_va(ms_error_va),
    .csr_busy(csr_busy), .ws_allowin(ws_allowin),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
    .csr_wr_en(csr_wr_en), .csr_era(csr_era), .csr_ecode(csr_ecode),
    .csr_esubcode(csr_esubcode), .bad_va(bad_va), .va_error(va_error),
    .retire_cnt(retire_cnt), .excp_cnt(excp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    ms_lane_vld = '0; ms_pc = '0; ms_result = '0; ms_error_va = '0; ms_dest = '0;
    ms_gr_we = '0; ms_ertn = '0; ms_csr_we = '0; ms_refetch = '0; ms_excp_num = '0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] pc, input logic [31:0] res,
                          input logic [4:0] dest, input logic gr_we, input logic ertn,
                          input logic csr_we, input logic refetch,
                          input logic [15:0] excp, input logic [31:0] va);
    ms_pc[l*32 +: 32]       = pc;
    ms_result[l*32 +: 32]   = res;
    ms_dest[l*5 +: 5]       = dest;
    ms_gr_we[l]             = gr_we;
    ms_ertn[l]              = ertn;
    ms_csr_we[l]            = csr_we;
    ms_refetch[l]           = refetch;
    ms_excp_num[l*16 +: 16] = excp;
    ms_error_va[l*32 +: 32] = va;
  endtask

  // Offers the prepared group for exactly one edge; the group is resident afterwards.
  task automatic applyStimulus(input logic [LANES-1:0] vld);
    ms_lane_vld    = vld;
    ms_to_ws_valid = 1'b1;
    tick();
    ms_to_ws_valid = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    exp_retire = '0; exp_excp = '0;
    resetn = 1'b0; ms_to_ws_valid = 1'b0; csr_busy = 1'b0;
    clear_lanes();
    tick(); tick();
    resetn = 1'b1;
    #1;
    checkOutput("rst_allowin", 64'(ws_allowin), 64'h1);
    checkOutput("rst_rf_we", 64'(rf_we), 64'h0);
    checkOutput("rst_retire", 64'(retire_cnt), 64'h0);
    checkOutput("rst_excp", 64'(excp_cnt), 64'h0);
    checkOutput("rst_flush", 64'({excp_flush, ertn_flush, refetch_flush, csr_wr_en}), 64'h0);

    // Two clean lanes retire together.
    clear_lanes();
    set_lane(0, 32'h100, 32'h11, 5'd3, 1, 0, 0, 0, 16'h0, 32'h0);
    set_lane(1, 32'h104, 32'h22, 5'd4, 1, 0, 0, 0, 16'h0, 32'h0);
    applyStimulus(2'b11);
    checkOutput("clean_rf_we", 64'(rf_we), 64'h3);
    checkOutput("clean_waddr", 64'(rf_waddr), 64'({5'd4, 5'd3}));
    checkOutput("clean_wdata", 64'(rf_wdata), 64'h00000022_00000011);
    checkOutput("clean_noflush", 64'({excp_flush, ertn_flush, refetch_flush}), 64'h0);
    tick();
    exp_retire = exp_retire + 4'd2;
    checkOutput("clean_retire", 64'(retire_cnt), 64'(exp_retire));
    checkOutput("clean_idle_we", 64'(rf_we), 64'h0);

    // Misaligned load on lane 0 with a new group still offered during the flush.
    clear_lanes();
    set_lane(0, 32'h200, 32'h33, 5'd6, 1, 0, 0, 0, 16'h0200, 32'h1003);
    set_lane(1, 32'h204, 32'h44, 5'd7, 1, 0, 0, 0, 16'h0, 32'h0);
    applyStimulus(2'b11);
    checkOutput("ale_flush", 64'(excp_flush), 64'h1);
    checkOutput("ale_ecode", 64'(csr_ecode), 64'h09);
    checkOutput("ale_esub", 64'(csr_esubcode), 64'h0);
    checkOutput("ale_bad_va", 64'(bad_va), 64'h1003);
    checkOutput("ale_va_error", 64'(va_error), 64'h1);
    checkOutput("ale_era", 64'(csr_era), 64'h200);
    checkOutput("ale_rf_we", 64'(rf_we), 64'h0);
    checkOutput("ale_other_flush", 64'({ertn_flush, refetch_flush, csr_wr_en}), 64'h0);
    ms_to_ws_valid = 1'b1;
    tick();
    ms_to_ws_valid = 1'b0;
    exp_excp = exp_excp + 4'd1;
    checkOutput("ale_excp_cnt", 64'(excp_cnt), 64'(exp_excp));
    checkOutput("ale_retire", 64'(retire_cnt), 64'(exp_retire));
    checkOutput("ale_cleared", 64'(excp_flush), 64'h0);
    checkOutput("ale_allowin", 64'(ws_allowin), 64'h1);

    // CSR write on lane 0 held off by csr_busy for three cycles.
    clear_lanes();
    set_lane(0, 32'h300, 32'h55, 5'd9, 1, 0, 1, 0, 16'h0, 32'h0);
    set_lane(1, 32'h304, 32'h66, 5'd10, 1, 0, 0, 0, 16'h0, 32'h0);
    csr_busy = 1'b1;
    applyStimulus(2'b11);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("stall%0d_allowin", c), 64'(ws_allowin), 64'h0);
      checkOutput($sformatf("stall%0d_csr_wr", c), 64'(csr_wr_en), 64'h0);
      checkOutput($sformatf("stall%0d_rf_we", c), 64'(rf_we), 64'h0);
      checkOutput($sformatf("stall%0d_refetch", c), 64'(refetch_flush), 64'h0);
      if (c < 2) tick();
    end
    csr_busy = 1'b0;
    #1;
    checkOutput("csr_wr_en", 64'(csr_wr_en), 64'h1);
    checkOutput("csr_refetch", 64'(refetch_flush), 64'h1);
    checkOutput("csr_rf_we", 64'(rf_we), 64'h1);
    checkOutput("csr_era", 64'(csr_era), 64'h300);
    checkOutput("csr_allowin", 64'(ws_allowin), 64'h1);
    tick();
    exp_retire = exp_retire + 4'd1;
    checkOutput("csr_pulse_end", 64'({csr_wr_en, refetch_flush}), 64'h0);
    checkOutput("csr_retire", 64'(retire_cnt), 64'(exp_retire));

    // Same destination on both lanes: only the younger write survives.
    clear_lanes();
    set_lane(0, 32'h400, 32'hA, 5'd5, 1, 0, 0, 0, 16'h0, 32'h0);
    set_lane(1, 32'h404, 32'hB, 5'd5, 1, 0, 0, 0, 16'h0, 32'h0);
    applyStimulus(2'b11);
    checkOutput("waw_rf_we", 64'(rf_we), 64'h2);
    checkOutput("waw_waddr1", 64'(rf_waddr[9:5]), 64'h5);
    checkOutput("waw_wdata1", 64'(rf_wdata[63:32]), 64'hB);
    tick();
    exp_retire = exp_retire + 4'd2;
    checkOutput("waw_retire", 64'(retire_cnt), 64'(exp_retire));

    // Lane 0 writes r0 (dropped); lane 1 ertn retires and flushes.
    clear_lanes();
    set_lane(0, 32'h500, 32'h77, 5'd0, 1, 0, 0, 0, 16'h0, 32'h0);
    set_lane(1, 32'h504, 32'h88, 5'd12, 0, 1, 0, 0, 16'h0, 32'h0);
    applyStimulus(2'b11);
    checkOutput("ertn_rf_we", 64'(rf_we), 64'h0);
    checkOutput("ertn_flush", 64'({excp_flush, ertn_flush, refetch_flush}), 64'h2);
    checkOutput("ertn_era", 64'(csr_era), 64'h504);
    checkOutput("ertn_va_error", 64'(va_error), 64'h0);
    tick();
    exp_retire = exp_retire + 4'd2;
    checkOutput("ertn_retire", 64'(retire_cnt), 64'(exp_retire));

    // Lane 1 carries ADEF plus ADEM; ADEF wins and reports the pc.
    clear_lanes();
    set_lane(0, 32'h600, 32'h99, 5'd2, 1, 0, 0, 0, 16'h0, 32'h0);
    set_lane(1, 32'h604, 32'hAA, 5'd13, 1, 0, 0, 0, 16'h0802, 32'h999);
    applyStimulus(2'b11);
    checkOutput("adef_rf_we", 64'(rf_we), 64'h1);
    checkOutput("adef_flush", 64'(excp_flush), 64'h1);
    checkOutput("adef_ecode", 64'(csr_ecode), 64'h08);
    checkOutput("adef_esub", 64'(csr_esubcode), 64'h0);
    checkOutput("adef_bad_va", 64'(bad_va), 64'h604);
    checkOutput("adef_va_error", 64'(va_error), 64'h1);
    tick();
    exp_retire = exp_retire + 4'd1;
    exp_excp   = exp_excp + 4'd1;
    checkOutput("adef_retire", 64'(retire_cnt), 64'(exp_retire));
    checkOutput("adef_excp_cnt", 64'(excp_cnt), 64'(exp_excp));

    // Run clean groups until the counter sits at 14, then two more retire and wrap.
    clear_lanes();
    set_lane(0, 32'h700, 32'h1, 5'd1, 1, 0, 0, 0, 16'h0, 32'h0);
    set_lane(1, 32'h704, 32'h2, 5'd2, 1, 0, 0, 0, 16'h0, 32'h0);
    for (int k = 0; k < 20 && exp_retire != 4'd14; k++) begin
      if (exp_retire == 4'd13) begin
        applyStimulus(2'b01);
        tick();
        exp_retire = exp_retire + 4'd1;
      end else begin
        applyStimulus(2'b11);
        tick();
        exp_retire = exp_retire + 4'd2;
      end
    end
    checkOutput("wrap_pre", 64'(retire_cnt), 64'he);
    applyStimulus(2'b11);
    tick();
    exp_retire = exp_retire + 4'd2;
    checkOutput("wrap_post", 64'(retire_cnt), 64'h0);

    // Reset lands while a CSR write is stalled.
    clear_lanes();
    set_lane(0, 32'h800, 32'h3, 5'd3, 1, 0, 1, 0, 16'h0, 32'h0);
    set_lane(1, 32'h804, 32'h4, 5'd4, 1, 0, 0, 0, 16'h0, 32'h0);
    csr_busy = 1'b1;
    applyStimulus(2'b11);
    checkOutput("rststall_allowin", 64'(ws_allowin), 64'h0);
    resetn = 1'b0;
    tick();
    checkOutput("rststall_allowin_after", 64'(ws_allowin), 64'h1);
    checkOutput("rststall_flush", 64'({excp_flush, ertn_flush, refetch_flush, csr_wr_en}), 64'h0);
    checkOutput("rststall_counters", 64'({retire_cnt, excp_cnt}), 64'h0);
    csr_busy = 1'b0;
    resetn   = 1'b1;
    #1;
    checkOutput("rststall_rf_we", 64'(rf_we), 64'h0);
    checkOutput("rststall_no_pulse", 64'({refetch_flush, csr_wr_en}), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_wb_stage.md
MULTI_WB_STAGE -- requirements
Module: multi_wb_stage

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning commit lanes per cycle (legal 1..4, lane 0 oldest).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of retire/exception counters.
REQ-003 SHALL have ports clk in 1 (system clock) and resetn in 1 (reset); one clock, reset synchronous active-low.
REQ-004 SHALL have port ms_to_ws_valid in 1, meaning a lane group is offered.
REQ-005 SHALL have port ms_lane_vld in LANES, meaning per-lane occupancy of the offered group.
REQ-006 SHALL have ports ms_pc/ms_result in 32*LANES, ms_dest in 5*LANES, ms_gr_we/ms_ertn/ms_csr_we/ms_refetch in LANES, and ms_excp_num in 16*LANES (per-lane fields).
REQ-007 SHALL have port ms_error_va in 32*LANES, meaning the per-lane data fault address.
REQ-008 SHALL have port csr_busy in 1, meaning the CSR unit cannot accept a write this cycle.
REQ-009 SHALL have port ws_allowin out 1, meaning the stage accepts a group this cycle.
REQ-010 SHALL have ports rf_we out LANES, rf_waddr out 5*LANES, rf_wdata out 32*LANES (register write ports).
REQ-011 SHALL have ports excp_flush/ertn_flush/refetch_flush out 1, csr_wr_en out 1, csr_era out 32, csr_ecode out 6, csr_esubcode out 9, bad_va out 32, va_error out 1.
REQ-012 SHALL have ports retire_cnt out CNT_W and excp_cnt out CNT_W (performance counters).

Function
REQ-013 SHALL hold a one-group register with ws_valid; ws_allowin = !ws_valid || ws_ready_go.
REQ-014 SHALL load the group when ms_to_ws_valid && ws_allowin, and set ws_valid <= ms_to_ws_valid whenever ws_allowin.
REQ-015 SHALL set ws_ready_go = !(csr_busy && the head-lane csr write is pending); a stalled group holds all outputs stable and issues no rf_we.
REQ-016 SHALL define the head lane as the lowest-index valid lane whose excp_num is nonzero or whose ertn, csr_we or refetch is set; when no lane qualifies, all lanes retire.
REQ-017 SHALL retire lanes below the head lane plus the head lane itself only when it is csr_we, refetch or ertn without an exception; lanes above the head lane are squashed.
REQ-018 SHALL assert rf_we[i] = retiring[i] && gr_we[i] && ready_go, except that lane i SHALL be suppressed when a younger retiring lane j>i writes the same nonzero dest.
REQ-019 SHALL never assert rf_we for dest 0.
REQ-020 SHALL drive excp_flush, ertn_flush and refetch_flush from the head lane only, one-hot, qualified by ws_valid && ready_go; refetch_flush covers csr_we or refetch.
REQ-021 SHALL drive csr_era as the head-lane pc; csr_wr_en SHALL pulse one cycle when the head lane has csr_we, no exception, and ready_go.
REQ-022 SHALL decode the head-lane excp_num by fixed priority, bit 0 highest, with bit 10 reserved.
REQ-023 SHALL, for bits 1-4, give va_error=1 and bad_va=pc; for bits 9 and 11-15, give va_error=1 and bad_va=error_va; for all other bits, give va_error=0 and bad_va=0.
REQ-024 SHALL, in the cycle any flush asserts, clear ws_valid on the next edge regardless of ms_to_ws_valid.
REQ-025 SHALL increase retire_cnt by popcount(retiring lanes) per completed cycle, wrapping modulo 2^CNT_W.
REQ-026 SHALL increment excp_cnt by 1 per excp_flush, wrapping modulo 2^CNT_W.
REQ-027 SHALL drive all flush, write and CSR outputs to 0 when ws_valid=0.

Reset
REQ-028 SHALL, when resetn=0 at a clk edge, clear ws_valid, retire_cnt and excp_cnt; the group register is not reset.
REQ-029 SHALL, on reset asserted mid-stall, discard the stalled group with no rf_we or flush in the following cycle.

Structure
REQ-030 SHALL place the ECODE/ESUBCODE constants, the excp_num bit indices and the lane-field widths in the shared package.
REQ-031 SHALL implement the priority exception decoder as sub-module wb_excp_decode, one instance on the head lane.

Verification
REQ-032 SHALL cover: LANES=2, both lanes valid and clean, dest 3 and 4 -> rf_we=2'b11 and retire_cnt +2.
REQ-033 SHALL cover: lane0 excp_num=16'h0200 (ALE) with error_va 0x1003, lane1 valid -> excp_flush=1, ecode=ALE, bad_va=0x1003, rf_we=0, excp_cnt +1, ws_valid=0 next cycle.
REQ-034 SHALL cover: lane0 csr_we with csr_busy=1 for 3 cycles -> ws_allowin=0 and csr_wr_en=0 for 3 cycles, then csr_wr_en and refetch_flush pulse once and lane1 is squashed.
REQ-035 SHALL cover: both lanes write dest 5 with 0xA then 0xB -> only rf_we[1]=1, wdata 0xB.
REQ-036 SHALL cover: retire_cnt preloaded near 2^CNT_W-1 via long run, then +2 -> counter wraps to 0 or 1.
REQ-037 SHALL cover: resetn=0 during a csr_busy stall -> next cycle ws_valid=0, no flush, counters 0.
